// File: rtl/encoder_layer_0_output_dense_pkg.sv
// Shared constants for the encoder layer 0 output-dense bias-add stage.
//
// Holds the fixed-point formats of the data, bias and output streams, the
// beat geometry, and the constants derived from them:
//   ALIGN_SHIFT - left shift that brings the bias onto the data binary point
//   ROUND_SHIFT - right shift that brings the sum onto the output binary point
//   SUM_WIDTH   - width of the aligned sum; wide enough that the add cannot overflow
//   RND_WIDTH   - width of the rounding intermediate (sum plus rounding carry)
//   SAT_MAX/MIN - output clamp bounds, expressed at RND_WIDTH
package encoder_layer_0_output_dense_pkg;

  localparam int DATA_IN_PRECISION_0  = 32;
  localparam int DATA_IN_PRECISION_1  = 6;
  localparam int BIAS_PRECISION_0     = 16;
  localparam int BIAS_PRECISION_1     = 3;
  localparam int DATA_OUT_PRECISION_0 = 16;
  localparam int DATA_OUT_PRECISION_1 = 3;

  localparam int TENSOR_SIZE_DIM_0 = 32;
  localparam int PARALLELISM_DIM_0 = 1;
  localparam int PARALLELISM_DIM_1 = 1;
  localparam int ROW_DEPTH         = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
  localparam int NUM_ELEM          = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int CNT_WIDTH         = $clog2(ROW_DEPTH) + 1;

  localparam int ALIGN_SHIFT = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
  localparam int ROUND_SHIFT = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SUM_WIDTH = max_int(DATA_IN_PRECISION_0, BIAS_PRECISION_0 + ALIGN_SHIFT) + 1;
  localparam int RND_WIDTH = SUM_WIDTH + 1;

  localparam logic signed [RND_WIDTH-1:0] SAT_MAX =
    (RND_WIDTH'(1) << (DATA_OUT_PRECISION_0 - 1)) - RND_WIDTH'(1);
  // Two's complement: the bitwise inverse of 2^(N-1)-1 is -2^(N-1).
  localparam logic signed [RND_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational round-and-saturate for one element.
//
// Takes the aligned sum (DATA_IN_PRECISION_1 fractional bits), rounds it
// half-up onto DATA_OUT_PRECISION_1 fractional bits with an arithmetic shift,
// then clamps it into the signed output range.
//   sum   in  [SUM_WIDTH-1:0]            signed aligned sum
//   value out [DATA_OUT_PRECISION_0-1:0] rounded, clamped result
//   sat   out 1                          high when the clamp was applied
module fixed_round_sat
  import encoder_layer_0_output_dense_pkg::*;
(
  input  logic [SUM_WIDTH-1:0]            sum,
  output logic [DATA_OUT_PRECISION_0-1:0] value,
  output logic                            sat
);

  logic signed [RND_WIDTH-1:0] sum_ext;
  logic signed [RND_WIDTH-1:0] rounded;

  // One guard bit above the sum so adding the half-LSB cannot wrap.
  assign sum_ext = {sum[SUM_WIDTH-1], sum};

  if (ROUND_SHIFT > 0) begin : g_round
    localparam logic signed [RND_WIDTH-1:0] HALF = RND_WIDTH'(1) << (ROUND_SHIFT - 1);
    assign rounded = (sum_ext + HALF) >>> ROUND_SHIFT;
  end else begin : g_pass
    assign rounded = sum_ext;
  end

  // NOTE: every output gets a default before the branches, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sat   = 1'b0;
    value = rounded[DATA_OUT_PRECISION_0-1:0];
    if (rounded > SAT_MAX) begin
      sat   = 1'b1;
      value = SAT_MAX[DATA_OUT_PRECISION_0-1:0];
    end else if (rounded < SAT_MIN) begin
      sat   = 1'b1;
      value = SAT_MIN[DATA_OUT_PRECISION_0-1:0];
    end
  end

endmodule

// File: rtl/encoder_layer_0_output_dense_bias_add.sv
// Streaming bias-add for the encoder layer 0 output projection.
//
// Joins one matmul beat with one bias beat, aligns the bias onto the data
// binary point and adds (stage 1), then rounds and saturates onto the output
// format (stage 2). Bias is broadcast across the PARALLELISM_DIM_1 rows.
//   clk, rst            clock; asynchronous active-low reset
//   data_in[*]          matmul beat, element j*P0+i is row j column i
//   data_in_valid/ready handshake of the data stream
//   bias[*]             bias beat, one entry per column
//   bias_valid/ready    handshake of the bias stream
//   data_out[*]         result beat
//   data_out_valid/ready handshake of the result stream
//   data_out_last       high on the final beat of each row
//   sat_flag            sticky; set once any element has been clamped
module encoder_layer_0_output_dense_bias_add
  import encoder_layer_0_output_dense_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_IN_PRECISION_0-1:0]  data_in [NUM_ELEM],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM_DIM_0],
  input  logic                            bias_valid,
  output logic                            bias_ready,
  output logic [DATA_OUT_PRECISION_0-1:0] data_out [NUM_ELEM],
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            data_out_last,
  output logic                            sat_flag
);

  logic                            s1_valid;
  logic                            s1_last;
  logic                            s1_ready;
  logic                            s2_ready;
  logic                            s2_load;
  logic                            fire;
  logic                            at_row_end;
  logic [CNT_WIDTH-1:0]            beat_cnt;
  logic [SUM_WIDTH-1:0]            sum_next  [NUM_ELEM];
  logic [SUM_WIDTH-1:0]            s1_sum    [NUM_ELEM];
  logic [DATA_OUT_PRECISION_0-1:0] rnd_value [NUM_ELEM];
  logic [NUM_ELEM-1:0]             rnd_sat;

  // Each stage accepts when empty or when its contents leave this cycle.
  // Stage 1 is held closed during reset so neither input reports ready.
  assign s2_ready = ~data_out_valid | data_out_ready;
  assign s1_ready = rst & (~s1_valid | s2_ready);
  assign s2_load  = s2_ready & s1_valid;

  // Each side's ready depends on the other side's valid so that neither
  // stream can be consumed without its partner.
  assign fire          = data_in_valid & bias_valid & s1_ready;
  assign data_in_ready = bias_valid & s1_ready;
  assign bias_ready    = data_in_valid & s1_ready;

  assign at_row_end = (beat_cnt == CNT_WIDTH'(ROW_DEPTH - 1));

  for (genvar j = 0; j < PARALLELISM_DIM_1; j++) begin : g_row
    for (genvar i = 0; i < PARALLELISM_DIM_0; i++) begin : g_col
      localparam int E = j * PARALLELISM_DIM_0 + i;
      logic signed [SUM_WIDTH-1:0] din_ext;
      logic signed [SUM_WIDTH-1:0] bias_ext;

      assign din_ext     = SUM_WIDTH'($signed(data_in[E]));
      assign bias_ext    = SUM_WIDTH'($signed(bias[i])) <<< ALIGN_SHIFT;
      assign sum_next[E] = din_ext + bias_ext;

      fixed_round_sat u_round_sat (
        .sum   (s1_sum[E]),
        .value (rnd_value[E]),
        .sat   (rnd_sat[E])
      );
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (s1_ready) s1_valid <= fire;
      if (fire) begin
        s1_last  <= at_row_end;
        beat_cnt <= at_row_end ? '0 : beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: the stage-1 sum is qualified by s1_valid everywhere it is used, so
  // it carries no reset; that keeps reset fanout off the wide datapath.
  always_ff @(posedge clk) begin
    if (fire) s1_sum <= sum_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      sat_flag       <= 1'b0;
      data_out       <= '{default: '0};
    end else begin
      if (s2_ready) data_out_valid <= s1_valid;
      if (s2_load) begin
        data_out      <= rnd_value;
        data_out_last <= s1_last;
        if (|rnd_sat) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/encoder_layer_0_output_dense_bias_add.md
Name: encoder_layer_0_output_dense_bias_add

Overview:
- Streaming bias-add stage directly downstream of the output-dense bias source, in the encoder layer 0 output projection.
- Joins the matmul result stream (data_in) with the bias stream (bias), one beat from each per transfer.
- Aligns fixed-point formats, adds, rounds and saturates to the output format.
- Emits a valid/ready stream with an end-of-row marker and a sticky saturation flag.

Parameters:
- DATA_IN_PRECISION_0, 32, data_in total bits (signed).
- DATA_IN_PRECISION_1, 6, data_in fractional bits.
- BIAS_PRECISION_0, 16, bias total bits (signed).
- BIAS_PRECISION_1, 3, bias fractional bits; must be <= DATA_IN_PRECISION_1.
- DATA_OUT_PRECISION_0, 16, output total bits (signed).
- DATA_OUT_PRECISION_1, 3, output fractional bits; must be <= DATA_IN_PRECISION_1.
- TENSOR_SIZE_DIM_0, 32, row length in elements.
- PARALLELISM_DIM_0, 1, elements per beat along dim 0; shared by data and bias.
- PARALLELISM_DIM_1, 1, rows per beat; bias is broadcast across these rows.
- ROW_DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0, beats per row.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  [DATA_IN_PRECISION_0-1:0] x P0*P1 (unpacked)  matmul result beat; element j*P0+i is row j, column i.
- data_in_valid  in  1
- data_in_ready  out  1
- bias  in  [BIAS_PRECISION_0-1:0] x P0*1 (unpacked)  bias beat.
- bias_valid  in  1
- bias_ready  out  1
- data_out  out  [DATA_OUT_PRECISION_0-1:0] x P0*P1 (unpacked)  result beat.
- data_out_valid  out  1
- data_out_ready  in  1
- data_out_last  out  1  high on the final beat of each row.
- sat_flag  out  1  sticky; set when any element saturates.

Behaviour:
- Reset (rst=0, asynchronous): both stage valids=0, data_out=0, data_out_last=0, sat_flag=0, beat counter=0. data_in_ready and bias_ready are 0 while rst is low.
- Join: fire = data_in_valid & bias_valid & s1_ready.
  - data_in_ready = bias_valid & s1_ready; bias_ready = data_in_valid & s1_ready.
  - Neither input is consumed alone.
- Pipeline: two register stages, each ready = !valid | downstream ready. This gives full throughput of one beat per cycle.
- Latency: data_out_valid rises 2 cycles after the fire edge. Stalls hold data_out and data_out_last stable.
- Stage 1 (align + add):
  - bias_aligned = sign-extend(bias) << (DATA_IN_PRECISION_1 - BIAS_PRECISION_1).
  - sum width = max(DATA_IN_PRECISION_0, BIAS_PRECISION_0 + shift) + 1. The add never overflows.
  - Stage 1 also registers the last flag: last = (counter == ROW_DEPTH-1).
- Stage 2 (round + saturate):
  - d = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1.
  - If d>0: r = (sum + (1<<(d-1))) >>> d (round-half-up, arithmetic). If d=0: r = sum.
  - Clamp r to [-2^(DATA_OUT_PRECISION_0-1), 2^(DATA_OUT_PRECISION_0-1)-1].
  - Any clamped element sets sat_flag on that stage-2 load. sat_flag clears only on reset.
- Beat counter: width $clog2(ROW_DEPTH)+1. Increments on each fire and wraps ROW_DEPTH-1 -> 0. It does not advance on stalls.
- Simultaneous events: stage 2 may drain and refill in the same cycle. Stage 1 may shift and accept a new fire in the same cycle.
- Reset mid-operation discards in-flight beats. The counter restarts at 0, so the next beat is column 0.

Decomposition:
- Package encoder_layer_0_output_dense_pkg holds:
  - precision localparams;
  - the aligned-shift constant and the round-shift constant;
  - sum-width constant;
  - saturation bound constants.
- One sub-module, fixed_round_sat: combinational per-element round + clamp. It outputs the value and a sat bit.
- One instance of fixed_round_sat per element of the beat.

Test Plan:
- Basic add: data_in=64 (1.0), bias=8 (1.0) -> data_out=16 (2.0), valid 2 cycles after fire, sat_flag=0.
- Rounding:
  - data_in=4, bias=0 -> 1 (0.5 rounds up).
  - data_in=-5, bias=0 -> -1.
  - data_in=3, bias=0 -> 0.
- Saturation:
  - data_in=0x7FFFFFFF, bias=8 -> 0x7FFF, sat_flag=1 and stays 1 after later in-range beats.
  - data_in=0x80000000, bias=-8 -> 0x8000.
- Join/backpressure:
  - Only bias_valid -> no fire, bias_ready=0.
  - data_out_ready low for 5 cycles with continuous inputs -> at most 2 beats buffered, data_out stable, no loss or duplication.
  - Release -> beats 1 per cycle, in order.
- Row marker: stream 64 beats with random valid/ready gaps -> data_out_last high exactly on beats 31 and 63.
- Async reset: assert rst=0 mid-stream between clock edges -> outputs clear immediately; after release, the first output beat has data_out_last=0 and the counter restarts at 0.
